// File: rtl/compute_read_load_pkg.sv
// Shared Dilithium constants, lane layout and load FSM encoding for compute_read_load.
package compute_read_load_pkg;

  localparam int unsigned DIL_Q        = 8380417;
  localparam int unsigned DIL_NUM_COEF = 256;

  localparam int unsigned COEF_W   = 23;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned CNT_W    = 7;
  localparam int unsigned TDATA_W  = 64;
  localparam int unsigned EVEN_LSB = 0;
  localparam int unsigned ODD_LSB  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } load_state_e;

  typedef struct packed {
    logic [COEF_W-1:0] odd;
    logic [COEF_W-1:0] even;
  } coef_pair_t;

endpackage

// File: rtl/compute_read_load_coef_lane_reduce.sv
// Single-lane conditional subtract of Q; only built when LOAD_RANGE_CHECK_EN is defined.
`ifdef LOAD_RANGE_CHECK_EN
module coef_lane_reduce
  import compute_read_load_pkg::*;
#(
  parameter int unsigned Q = DIL_Q
) (
  input  logic [COEF_W-1:0] coef_i,
  output logic [COEF_W-1:0] coef_c,
  output logic              oor_c
);

  localparam logic [COEF_W-1:0] QV = COEF_W'(Q);

  // Fold any value at or above Q back by one modulus
  always_comb begin
    oor_c  = (coef_i >= QV);
    coef_c = oor_c ? (coef_i - QV) : coef_i;
  end

endmodule
`endif

// File: rtl/compute_read_load.sv
// Streams NUM_COEF/2 coefficient pairs from a FIFO into a dual-port coefficient RAM.
// Optional range folding/flagging is enabled by defining LOAD_RANGE_CHECK_EN.
module compute_read_load
  import compute_read_load_pkg::*;
#(
  parameter int unsigned Q        = DIL_Q,
  parameter int unsigned NUM_COEF = DIL_NUM_COEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  output logic               load_busy,
  output logic               load_done,
  input  logic               Read_FIFO_tvalid,
  input  logic [TDATA_W-1:0] Read_FIFO_tdata,
  output logic               Read_FIFO_tready,
  output logic               coef_ena,
  output logic               coef_wea,
  output logic [ADDR_W-1:0]  coef_addra,
  output logic [COEF_W-1:0]  coef_dina,
  output logic               coef_enb,
  output logic               coef_web,
  output logic [ADDR_W-1:0]  coef_addrb,
  output logic [COEF_W-1:0]  coef_dinb,
  output logic               range_err
);

  localparam int unsigned LAST_BEAT = NUM_COEF / 2 - 1;

  load_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addra_q, addra_d;
  logic [ADDR_W-1:0]  addrb_q, addrb_d;
  logic [COEF_W-1:0]  dina_q, dina_d;
  logic [COEF_W-1:0]  dinb_q, dinb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept;
  logic               start_acc;
  logic               last_beat;
  coef_pair_t         pair;
  logic [COEF_W-1:0]  even_w, odd_w;
  logic               unused_bits;

  assign pair = coef_pair_t'({Read_FIFO_tdata[ODD_LSB +: COEF_W],
                              Read_FIFO_tdata[EVEN_LSB +: COEF_W]});
  assign unused_bits = ^{Read_FIFO_tdata[ODD_LSB-1:EVEN_LSB+COEF_W],
                         Read_FIFO_tdata[TDATA_W-1:ODD_LSB+COEF_W]};

  assign Read_FIFO_tready = (state_q == ST_LOAD);
  assign accept    = Read_FIFO_tready & Read_FIFO_tvalid;
  assign start_acc = (state_q == ST_IDLE) & load_start;
  assign last_beat = accept & (cnt_q == CNT_W'(LAST_BEAT));

`ifdef LOAD_RANGE_CHECK_EN
  logic oor_even, oor_odd;
  logic err_q, err_d;

  coef_lane_reduce #(.Q(Q)) u_reduce_even (
    .coef_i (pair.even),
    .coef_c (even_w),
    .oor_c  (oor_even)
  );

  coef_lane_reduce #(.Q(Q)) u_reduce_odd (
    .coef_i (pair.odd),
    .coef_c (odd_w),
    .oor_c  (oor_odd)
  );

  // Sticky range flag, cleared by an accepted start
  always_comb begin
    err_d = err_q;
    if (start_acc) begin
      err_d = 1'b0;
    end else if (accept) begin
      err_d = err_q | oor_even | oor_odd;
    end
  end

  // Range flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign range_err = err_q;
`else
  localparam int unsigned unused_q = Q;

  assign even_w    = pair.even;
  assign odd_w     = pair.odd;
  assign range_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; FLUSH lasts exactly the final write cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load_start) state_d = ST_LOAD;
      ST_LOAD:  if (last_beat)  state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values: accepted beat becomes a RAM write one cycle later
  always_comb begin
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    addra_d = '0;
    addrb_d = '0;
    dina_d  = '0;
    dinb_d  = '0;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_q == ST_FLUSH);
    if (start_acc) begin
      cnt_d = '0;
    end
    if (accept) begin
      wr_d    = 1'b1;
      addra_d = {cnt_q, 1'b0};
      addrb_d = {cnt_q, 1'b1};
      dina_d  = even_w;
      dinb_d  = odd_w;
      if (!last_beat) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addra_q <= '0;
      addrb_q <= '0;
      dina_q  <= '0;
      dinb_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addra_q <= addra_d;
      addrb_q <= addrb_d;
      dina_q  <= dina_d;
      dinb_q  <= dinb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign coef_ena   = wr_q;
  assign coef_wea   = wr_q;
  assign coef_enb   = wr_q;
  assign coef_web   = wr_q;
  assign coef_addra = addra_q;
  assign coef_addrb = addrb_q;
  assign coef_dina  = dina_q;
  assign coef_dinb  = dinb_q;
  assign load_busy  = busy_q;
  assign load_done  = done_q;

endmodule
